// File: rtl/syn_m_tx_sched.sv
// syn_m_tx_sched
// ---------------------------------------------------------------------------
// Fixed-priority scheduler that shares one tx_info_phy byte transmitter
// between three frame sources of the master sync path:
//   source 0 : UTC seconds   (highest priority)
//   source 1 : status word
//   source 2 : command word  (lowest priority)
// Each source request is latched together with its payload and byte count.
// One source at a time is granted, and its payload is sent MSB-first as
// 0-4 bytes over the phy fire_tx/done_tx handshake. Every byte is guarded
// by a timeout counted in microsecond ticks.
//
// Ports
//   clk_sys           system clock, rising edge
//   rst_n             asynchronous active-low reset
//   pluse_us          one-cycle pulse every microsecond
//   reqN / datN / lenN  frame request, 32-bit payload, byte count (N = 0..2)
//   ackN              one-cycle pulse when source N's frame completes
//   fire_tx / data_tx start-byte pulse and byte to the phy
//   done_tx           phy byte-complete pulse
//   busy              scheduler is serving a frame
//   grant             index of the served source, 2'd3 when idle
//   err / err_cnt     timeout-abort pulse and saturating abort count
// ---------------------------------------------------------------------------
module syn_m_tx_sched #(
  parameter logic [19:0] TO_US = 20'd200
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic        req0,
  input  logic        req1,
  input  logic        req2,
  input  logic [31:0] dat0,
  input  logic [31:0] dat1,
  input  logic [31:0] dat2,
  input  logic [2:0]  len0,
  input  logic [2:0]  len1,
  input  logic [2:0]  len2,
  output logic        ack0,
  output logic        ack1,
  output logic        ack2,
  output logic        fire_tx,
  output logic [7:0]  data_tx,
  input  logic        done_tx,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFire,
    StWait,
    StDone,
    StAbort
  } state_e;

  // Lengths above 4 bytes are clamped to a full word.
  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'd4) ? 3'd4 : l;
  endfunction

  // Move the first byte to send (payload[8*len-1 -: 8]) to bits [31:24] so
  // every byte can then be taken from the top of a left-shifting register.
  function automatic logic [31:0] align_msb(input logic [31:0] d, input logic [2:0] l);
    logic [31:0] r;
    case (l)
      3'd1:    r = {d[7:0], 24'h0};
      3'd2:    r = {d[15:0], 16'h0};
      3'd3:    r = {d[23:0], 8'h0};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request inputs gathered into vectors.
  logic [2:0]       req_w;
  logic [2:0][31:0] dat_w;
  logic [2:0][2:0]  len_w;

  assign req_w = {req2, req1, req0};
  assign dat_w = {dat2, dat1, dat0};
  assign len_w = {len2, len1, len0};

  // State.
  state_e           state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0][31:0] pdat_q, pdat_d;
  logic [2:0][2:0]  plen_q, plen_d;
  logic [31:0]      sh_q, sh_d;       // working payload, next byte at [31:24]
  logic [2:0]       cnt_q, cnt_d;     // bytes still to be fired
  logic [1:0]       gnt_q, gnt_d;
  logic [19:0]      to_q, to_d;
  logic             fire_q, fire_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic [7:0]       errc_q, errc_d;

  // Fixed-priority pick among pending sources: lowest index wins.
  logic [1:0]  sel_idx;
  logic [2:0]  sel_oh;
  logic [31:0] sel_dat;
  logic [2:0]  sel_len;

  always_comb begin
    sel_idx = 2'd2;
    sel_oh  = 3'b100;
    sel_dat = pdat_q[2];
    sel_len = plen_q[2];
    if (pend_q[0]) begin
      sel_idx = 2'd0;
      sel_oh  = 3'b001;
      sel_dat = pdat_q[0];
      sel_len = plen_q[0];
    end else if (pend_q[1]) begin
      sel_idx = 2'd1;
      sel_oh  = 3'b010;
      sel_dat = pdat_q[1];
      sel_len = plen_q[1];
    end
  end

  // Timeout detection looks at the count including this cycle's tick, so the
  // abort state (and err) follows the TO_US-th tick by exactly one cycle.
  logic [20:0] to_inc;
  logic        to_hit;

  assign to_inc = {1'b0, to_q} + {20'h0, pluse_us};
  assign to_hit = (to_inc >= {1'b0, TO_US});

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pdat_d  = pdat_q;
    plen_d  = plen_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    to_d    = to_q;
    fire_d  = 1'b0;
    data_d  = data_q;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    errc_d  = errc_q;

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StLoad;
          gnt_d   = sel_idx;
          cnt_d   = sel_len;
          sh_d    = align_msb(sel_dat, sel_len);
          pend_d  = pend_q & ~sel_oh;
        end
      end
      StLoad: begin
        if (cnt_q == 3'd0) begin
          state_d = StDone;
          ack_d   = 3'b001 << gnt_q;
        end else begin
          state_d = StFire;
          fire_d  = 1'b1;
          data_d  = sh_q[31:24];
          sh_d    = {sh_q[23:0], 8'h0};
          cnt_d   = cnt_q - 3'd1;
        end
      end
      StFire: begin
        state_d = StWait;
        to_d    = 20'h0;
      end
      StWait: begin
        // done_tx takes precedence over a timeout in the same cycle.
        if (done_tx) begin
          if (cnt_q != 3'd0) begin
            state_d = StFire;
            fire_d  = 1'b1;
            data_d  = sh_q[31:24];
            sh_d    = {sh_q[23:0], 8'h0};
            cnt_d   = cnt_q - 3'd1;
          end else begin
            state_d = StDone;
            ack_d   = 3'b001 << gnt_q;
          end
        end else if (to_hit) begin
          state_d = StAbort;
          err_d   = 1'b1;
          errc_d  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
        end else begin
          to_d = to_inc[19:0];
        end
      end
      StDone:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A new request always wins over the grant-time clear and replaces any
    // un-granted older frame of the same source.
    for (int i = 0; i < 3; i++) begin
      if (req_w[i]) begin
        pend_d[i] = 1'b1;
        pdat_d[i] = dat_w[i];
        plen_d[i] = clamp_len(len_w[i]);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= 3'b000;
      pdat_q  <= '0;
      plen_q  <= '0;
      sh_q    <= 32'h0;
      cnt_q   <= 3'd0;
      gnt_q   <= 2'd0;
      to_q    <= 20'h0;
      fire_q  <= 1'b0;
      data_q  <= 8'h0;
      ack_q   <= 3'b000;
      err_q   <= 1'b0;
      errc_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pdat_q  <= pdat_d;
      plen_q  <= plen_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
      fire_q  <= fire_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  assign fire_tx = fire_q;
  assign data_tx = data_q;
  assign ack0    = ack_q[0];
  assign ack1    = ack_q[1];
  assign ack2    = ack_q[2];
  assign err     = err_q;
  assign err_cnt = errc_q;
  assign busy    = (state_q != StIdle);
  assign grant   = (state_q == StIdle) ? 2'd3 : gnt_q;

endmodule

// File: tb/tb_syn_m_tx_sched.sv
// Testbench for syn_m_tx_sched: directed frames, a phy model answering each
// fire_tx with done_tx a fixed number of cycles later, and a scoreboard that
// compares every byte / ack / err event the DUT presents against a queue of
// hand-computed expectations.
module tb_syn_m_tx_sched;

  localparam logic [19:0] ToUs   = 20'd5;
  localparam int          PhyDly = 5;

  localparam logic [1:0] EvByte = 2'd0;
  localparam logic [1:0] EvAck  = 2'd1;
  localparam logic [1:0] EvErr  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] gnt;
    logic [7:0] val;
  } ev_t;

  logic        clk_sys;
  logic        rst_n;
  logic        pluse_us;
  logic        req0, req1, req2;
  logic [31:0] dat0, dat1, dat2;
  logic [2:0]  len0, len1, len2;
  logic        ack0, ack1, ack2;
  logic        fire_tx;
  logic [7:0]  data_tx;
  logic        done_tx;
  logic        busy;
  logic [1:0]  grant;
  logic        err;
  logic [7:0]  err_cnt;

  logic phy_done;
  logic man_done;
  logic phy_en;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  assign done_tx = phy_done | man_done;

  syn_m_tx_sched #(
    .TO_US(ToUs)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .pluse_us(pluse_us),
    .req0    (req0),
    .req1    (req1),
    .req2    (req2),
    .dat0    (dat0),
    .dat1    (dat1),
    .dat2    (dat2),
    .len0    (len0),
    .len1    (len1),
    .len2    (len2),
    .ack0    (ack0),
    .ack1    (ack1),
    .ack2    (ack2),
    .fire_tx (fire_tx),
    .data_tx (data_tx),
    .done_tx (done_tx),
    .busy    (busy),
    .grant   (grant),
    .err     (err),
    .err_cnt (err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [1:0] g, input logic [7:0] v);
    exp_q.push_back({EvByte, g, v});
  endtask

  task automatic push_ack(input logic [1:0] g);
    exp_q.push_back({EvAck, g, 8'h00});
  endtask

  task automatic push_err(input logic [1:0] g, input logic [7:0] cnt);
    exp_q.push_back({EvErr, g, cnt});
  endtask

  task automatic set_req(input int src, input logic [31:0] d, input logic [2:0] l);
    case (src)
      0: begin req0 = 1'b1; dat0 = d; len0 = l; end
      1: begin req1 = 1'b1; dat1 = d; len1 = l; end
      default: begin req2 = 1'b1; dat2 = d; len2 = l; end
    endcase
  endtask

  task automatic end_req();
    @(posedge clk_sys); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
  endtask

  task automatic issue(input int src, input logic [31:0] d, input logic [2:0] l);
    @(posedge clk_sys); #1;
    set_req(src, d, l);
    end_req();
  endtask

  // Returns at the falling edge of the next cycle with fire_tx high.
  task automatic wait_fire(input string name);
    int k;
    k = 0;
    @(negedge clk_sys);
    while (!fire_tx && k < 60) begin
      @(negedge clk_sys);
      k++;
    end
    if (!fire_tx) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_fire_timeout got=no fire_tx required=fire_tx", name);
    end
  endtask

  // Waits for the scoreboard to empty and the scheduler to go idle.
  task automatic wait_drain(input string name);
    int k;
    k = 0;
    @(negedge clk_sys);
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    chk({name, "_pending_events"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle_grant"}, 32'(grant), 32'd3);
  endtask

  task automatic us_pulses(input int n, input bit done_on_last);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk_sys); #1;
      pluse_us = 1'b1;
      if (done_on_last && i == n) man_done = 1'b1;
      @(posedge clk_sys); #1;
      pluse_us = 1'b0;
      man_done = 1'b0;
    end
  endtask

  // Phy model: done_tx PhyDly cycles after each fire_tx.
  initial begin
    phy_done = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (fire_tx && phy_en) begin
        repeat (PhyDly) @(posedge clk_sys);
        #1 phy_done = 1'b1;
        @(posedge clk_sys);
        #1 phy_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    ev_t got;
    ev_t want;
    forever begin
      @(negedge clk_sys);
      if (fire_tx || err || ack0 || ack1 || ack2) begin
        if (fire_tx) got = {EvByte, grant, data_tx};
        else if (err) got = {EvErr, grant, err_cnt};
        else got = {EvAck, (ack2 ? 2'd2 : (ack1 ? 2'd1 : 2'd0)), 8'h00};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event got=%h required=none", got);
        end else begin
          want = exp_q.pop_front();
          chk("scoreboard_event", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n    = 1'b0;
    pluse_us = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    dat0 = 32'h0; dat1 = 32'h0; dat2 = 32'h0;
    len0 = 3'd0; len1 = 3'd0; len2 = 3'd0;
    man_done = 1'b0;
    phy_en   = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk_sys);
    chk("rst_fire", 32'(fire_tx), 32'd0);
    chk("rst_data", 32'(data_tx), 32'h0);
    chk("rst_ack", 32'({ack2, ack1, ack0}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd3);
    rst_n = 1'b1;

    // Single UTC frame with latency checks.
    push_byte(2'd0, 8'h12);
    push_byte(2'd0, 8'h34);
    push_byte(2'd0, 8'h56);
    push_byte(2'd0, 8'h78);
    push_ack(2'd0);
    issue(0, 32'h1234_5678, 3'd4);
    @(negedge clk_sys);
    chk("utc_c1_busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    chk("utc_c2_busy", 32'(busy), 32'd1);
    chk("utc_c2_fire", 32'(fire_tx), 32'd0);
    chk("utc_c2_grant", 32'(grant), 32'd0);
    @(negedge clk_sys);
    chk("utc_c3_fire", 32'(fire_tx), 32'd1);
    chk("utc_c3_data", 32'(data_tx), 32'h12);
    wait_drain("utc");
    chk("utc_err_cnt", 32'(err_cnt), 32'd0);

    // Priority: req2 and req0 together, req1 while frame 0 runs.
    push_byte(2'd0, 8'hEE);
    push_ack(2'd0);
    push_byte(2'd1, 8'h11);
    push_ack(2'd1);
    push_byte(2'd2, 8'hAB);
    push_byte(2'd2, 8'hCD);
    push_ack(2'd2);
    @(posedge clk_sys); #1;
    set_req(2, 32'h0000_ABCD, 3'd2);
    set_req(0, 32'h0000_00EE, 3'd1);
    end_req();
    wait_fire("prio");
    issue(1, 32'h0000_0011, 3'd1);
    wait_drain("prio");

    // Overwrite: two req1 while source 0 is busy; only the newer one is sent.
    push_byte(2'd0, 8'h01);
    push_byte(2'd0, 8'h02);
    push_ack(2'd0);
    push_byte(2'd1, 8'hBB);
    push_ack(2'd1);
    issue(0, 32'h0000_0102, 3'd2);
    wait_fire("ovr");
    issue(1, 32'h0000_00AA, 3'd1);
    issue(1, 32'h0000_00BB, 3'd1);
    wait_drain("ovr");

    // Empty frame: ack in cycle 3, no fire_tx.
    push_ack(2'd2);
    issue(2, 32'hFFFF_FFFF, 3'd0);
    @(negedge clk_sys);
    chk("len0_c1_fire", 32'(fire_tx), 32'd0);
    @(negedge clk_sys);
    chk("len0_c2_fire", 32'(fire_tx), 32'd0);
    @(negedge clk_sys);
    chk("len0_c3_ack", 32'(ack2), 32'd1);
    chk("len0_c3_fire", 32'(fire_tx), 32'd0);
    wait_drain("len0");

    // Length 7 clamps to 4 bytes.
    push_byte(2'd0, 8'hA1);
    push_byte(2'd0, 8'hB2);
    push_byte(2'd0, 8'hC3);
    push_byte(2'd0, 8'hD4);
    push_ack(2'd0);
    issue(0, 32'hA1B2_C3D4, 3'd7);
    wait_drain("len7");

    // done_tx coincident with the timeout tick completes normally.
    phy_en = 1'b0;
    push_byte(2'd1, 8'h3C);
    push_ack(2'd1);
    issue(1, 32'h0000_003C, 3'd1);
    wait_fire("race");
    us_pulses(5, 1'b1);
    @(negedge clk_sys);
    chk("race_ack", 32'(ack1), 32'd1);
    chk("race_err", 32'(err), 32'd0);
    wait_drain("race");
    chk("race_err_cnt", 32'(err_cnt), 32'd0);

    // Timeout: phy silent, abort after the 5th microsecond tick.
    push_byte(2'd1, 8'h5A);
    push_err(2'd1, 8'd1);
    issue(1, 32'h0000_005A, 3'd1);
    wait_fire("tmo");
    us_pulses(4, 1'b0);
    @(negedge clk_sys);
    chk("tmo_before_err", 32'(err), 32'd0);
    chk("tmo_before_busy", 32'(busy), 32'd1);
    us_pulses(1, 1'b0);
    @(negedge clk_sys);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
    @(negedge clk_sys);
    chk("tmo_err_clear", 32'(err), 32'd0);
    chk("tmo_idle", 32'(busy), 32'd0);
    wait_drain("tmo");
    phy_en = 1'b1;

    // Reset during byte 2, with source 1 pending.
    push_byte(2'd0, 8'h11);
    push_byte(2'd0, 8'h22);
    issue(0, 32'h1122_3344, 3'd4);
    wait_fire("rstm_b1");
    issue(1, 32'h0000_0077, 3'd1);
    wait_fire("rstm_b2");
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_grant", 32'(grant), 32'd3);
    chk("rstm_fire", 32'(fire_tx), 32'd0);
    chk("rstm_data", 32'(data_tx), 32'h0);
    chk("rstm_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    chk("rstm_after_busy", 32'(busy), 32'd0);
    chk("rstm_after_events", 32'(exp_q.size()), 32'd0);

    // Scheduler still works after the reset.
    push_byte(2'd2, 8'h99);
    push_ack(2'd2);
    issue(2, 32'h0000_0099, 3'd1);
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
